// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture path.
// Default widths and capture FSM state codes.
package scope_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 560;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample stream in, RAM write port out.
// master = capture controller side, slave = source/RAM side.
interface capture_ctrl_if
    import scope_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  s_valid,
        input  s_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output s_valid,
        output s_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/trig_edge_det.sv
// Trigger rising-edge detector with a pending flag that
// holds an event seen on an invalid sample cycle.
module trig_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic trig_in,
    input  logic force_trig,
    input  logic arm,
    input  logic enable,
    input  logic consume,
    output logic trig_evt,
    output logic pending
);

    logic trig_q;

    assign trig_evt = (trig_in & ~trig_q) | force_trig;

    // trig_in delay every cycle; pending set in WAIT, cleared on arm/consume
    always_ff @(posedge clk) begin
        if (!rstn) begin
            trig_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            trig_q <= trig_in;
            if (arm || consume) begin
                pending <= 1'b0;
            end else if (enable && trig_evt) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Write-side controller for the scope sample RAM:
// pre-trigger ring fill, trigger wait, fixed post-trigger count.
module capture_ctrl
    import scope_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              arm,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    input  logic              trig_in,
    input  logic              force_trig,
    capture_ctrl_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] pre_q;
    logic [ADDR_W-1:0] post_q;
    logic [ADDR_W-1:0] post_eff;
    logic [ADDR_W:0]   len_sum;
    logic              en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              run;
    logic              accept;
    logic              fire;
    logic              trig_evt;
    logic              pending;

    // pre+post+1 exceeds the depth exactly when the sum carries out;
    // then post becomes depth-1-pre, which is ~pre_len
    assign len_sum  = {1'b0, pre_len} + {1'b0, post_len};
    assign post_eff = len_sum[ADDR_W] ? ~pre_len : post_len;

    assign run    = (state == ST_PRE) || (state == ST_WAIT)
                 || (state == ST_POST);
    assign accept = run & bus.s_valid & ~arm;
    assign fire   = accept & (state == ST_WAIT) & (trig_evt | pending);

    assign busy = run;
    assign done = (state == ST_DONE);

    assign bus.wr_en   = en_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;

    trig_edge_det u_edge (
        .clk        (clk),
        .rstn       (rstn),
        .trig_in    (trig_in),
        .force_trig (force_trig),
        .arm        (arm),
        .enable     (state == ST_WAIT),
        .consume    (fire),
        .trig_evt   (trig_evt),
        .pending    (pending)
    );

    // FSM, write pointer, phase counter and registered write port
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            pre_q      <= '0;
            post_q     <= '0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            en_q <= accept;
            if (accept) begin
                addr_q <= ptr;
                data_q <= bus.s_data;
                ptr    <= ptr + ONE;
            end
            if (arm) begin
                pre_q  <= pre_len;
                post_q <= post_eff;
                ptr    <= '0;
                cnt    <= '0;
                state  <= (pre_len == '0) ? ST_WAIT : ST_PRE;
            end else begin
                case (state)
                    ST_PRE: begin
                        if (accept) begin
                            if (cnt + ONE == pre_q) begin
                                state <= ST_WAIT;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (fire) begin
                            trig_addr  <= ptr;
                            start_addr <= ptr - pre_q;
                            cnt        <= '0;
                            state      <= (post_q == '0) ? ST_DONE
                                                         : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (accept) begin
                            if (cnt + ONE == post_q) begin
                                state <= ST_DONE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized scoreboard bench for capture_ctrl with a
// sample-count reference model of the capture window.
module tb_capture_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 560;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          arm;
    logic [AW-1:0] pre_len;
    logic [AW-1:0] post_len;
    logic          trig_in;
    logic          force_trig;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;

    capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .arm        (arm),
        .pre_len    (pre_len),
        .post_len   (post_len),
        .trig_in    (trig_in),
        .force_trig (force_trig),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr),
        .start_addr (start_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        bit            wen;
        bit            busy;
        bit            done;
        bit            zero;
        logic [AW-1:0] ta;
        logic [AW-1:0] sa;
    } st_t;

    wr_t exp_wr[$];
    st_t exp_st[$];
    int  n_vec   = 0;
    int  n_err   = 0;
    int  wr_seen = 0;

    // reference model: window described by sample counts
    bit m_act, m_done, m_tseen, m_pend, m_trq;
    int m_n, m_pre, m_post, m_tidx, m_ta, m_sa;

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [575:0] t;
        for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    // model step on every edge using the inputs the DUT samples
    always @(posedge clk) begin : model
        st_t s;
        wr_t w;
        bit  ev;
        bit  in_wait;
        s.wen  = 1'b0;
        s.zero = 1'b0;
        if (!rstn) begin
            m_act = 0; m_done = 0; m_tseen = 0; m_pend = 0; m_trq = 0;
            m_n = 0; m_pre = 0; m_post = 0; m_tidx = 0;
            m_ta = 0; m_sa = 0;
            s.zero = 1'b1;
        end else begin
            if (arm) begin
                m_pre  = int'(pre_len);
                m_post = (m_pre + int'(post_len) + 1 > DEPTH)
                       ? DEPTH - 1 - m_pre : int'(post_len);
                m_n = 0; m_act = 1; m_done = 0; m_tseen = 0; m_pend = 0;
            end else if (m_act) begin
                in_wait = (m_n >= m_pre) && !m_tseen;
                ev      = (trig_in && !m_trq) || force_trig;
                if (bus.s_valid) begin
                    w.addr = AW'(m_n % DEPTH);
                    w.data = bus.s_data;
                    exp_wr.push_back(w);
                    s.wen = 1'b1;
                    if (in_wait && (ev || m_pend)) begin
                        m_tseen = 1;
                        m_tidx  = m_n;
                        m_ta    = m_n % DEPTH;
                        m_sa    = (m_n - m_pre) % DEPTH;
                        m_pend  = 0;
                    end
                    m_n++;
                    if (m_tseen && m_n == m_tidx + 1 + m_post) begin
                        m_act  = 0;
                        m_done = 1;
                    end
                end else if (in_wait && ev) begin
                    m_pend = 1;
                end
            end
            m_trq = trig_in;
        end
        s.busy = m_act;
        s.done = m_done;
        s.ta   = AW'(m_ta);
        s.sa   = AW'(m_sa);
        exp_st.push_back(s);
    end

    // monitor: compare registered outputs just after each edge
    always @(posedge clk) begin : mon
        st_t s;
        wr_t w;
        #1;
        if (exp_st.size() != 0) begin
            s = exp_st.pop_front();
            chk("wr_en", bus.wr_en, s.wen);
            chk("busy", busy, s.busy);
            chk("done", done, s.done);
            chk("trig_addr", trig_addr, s.ta);
            chk("start_addr", start_addr, s.sa);
            if (s.zero) begin
                chk("rst_wr_addr", bus.wr_addr, '0);
                chk("rst_wr_data", bus.wr_data, '0);
            end
            if (bus.wr_en) wr_seen++;
            if (bus.wr_en && s.wen && exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("wr_addr", bus.wr_addr, w.addr);
                chk("wr_data", bus.wr_data, w.data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(bit v);
        bus.s_valid = v;
        bus.s_data  = rnd_data();
    endtask

    task automatic do_arm(int p, int q);
        arm         = 1'b1;
        pre_len     = AW'(p);
        post_len    = AW'(q);
        force_trig  = 1'b0;
        bus.s_valid = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(int maxc, int vmod, string nm);
        for (int i = 0; i < maxc && !done; i++) begin
            drive((i % vmod) == 0);
            tick();
        end
        chk({nm, "_done"}, done, 1);
        drive(0);
    endtask

    initial begin
        int base;
        rstn = 0; arm = 0; pre_len = '0; post_len = '0;
        trig_in = 0; force_trig = 0;
        bus.s_valid = 0; bus.s_data = '0;
        repeat (3) tick();
        rstn = 1;
        tick();

        // 1: pre 4 post 3, trigger after 10 WAIT samples
        base = wr_seen;
        do_arm(4, 3);
        for (int i = 0; i < 14; i++) begin drive(1); tick(); end
        trig_in = 1;
        wait_done(20, 1, "s1");
        trig_in = 0;
        chk("s1_trig_addr", trig_addr, 14);
        chk("s1_start_addr", start_addr, 10);
        chk("s1_writes", wr_seen - base, 18);

        // 2: zero lengths, software trigger
        base = wr_seen;
        do_arm(0, 0);
        force_trig = 1; drive(1); tick();
        force_trig = 0;
        chk("s2_done", done, 1);
        repeat (3) begin drive(1); tick(); end
        drive(0);
        chk("s2_trig_addr", trig_addr, 0);
        chk("s2_start_addr", start_addr, 0);
        chk("s2_writes", wr_seen - base, 1);

        // 3: sparse valid, edge on an invalid cycle
        do_arm(8, 4);
        for (int c = 0; c < 62; c++) begin
            drive((c % 3) == 0);
            trig_in = (c >= 61);
            tick();
        end
        wait_done(40, 3, "s3");
        trig_in = 0;

        // 4: clamped post length with ring wrap
        base = wr_seen;
        do_arm(1000, 1000);
        for (int i = 0; i < 2100; i++) begin drive(1); tick(); end
        trig_in = 1;
        wait_done(40, 1, "s4");
        trig_in = 0;
        chk("s4_trig_addr", trig_addr, 52);
        chk("s4_start_addr", start_addr, 76);
        chk("s4_writes", wr_seen - base, 2124);

        // 5: level held high through PRE, then re-arm mid-POST
        trig_in = 1;
        do_arm(5, 6);
        for (int i = 0; i < 25; i++) begin drive(1); tick(); end
        chk("s5_no_trig_busy", busy, 1);
        trig_in = 0; drive(1); tick();
        trig_in = 1; drive(1); tick();
        repeat (2) begin drive(1); tick(); end
        trig_in = 0;
        do_arm(2, 2);
        chk("s5_rearm_done", done, 0);
        chk("s5_rearm_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin drive(1); tick(); end
        trig_in = 1;
        wait_done(20, 1, "s5");
        trig_in = 0;

        // 6: reset during WAIT, then a normal run
        do_arm(3, 5);
        repeat (6) begin drive(1); tick(); end
        rstn = 0; drive(1); tick();
        rstn = 1; drive(0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_trig_addr", trig_addr, 0);
        do_arm(2, 2);
        repeat (4) begin drive(1); tick(); end
        force_trig = 1; drive(1); tick();
        force_trig = 0;
        wait_done(20, 1, "s6");

        // random acquisitions with aborts and resets
        for (int r = 0; r < 25; r++) begin
            int p;
            int q;
            p = ($urandom % 4 == 0) ? int'($urandom % DEPTH)
                                    : int'($urandom % 20);
            q = ($urandom % 4 == 0) ? int'($urandom % DEPTH)
                                    : int'($urandom % 20);
            do_arm(p, q);
            for (int c = 0; c < 400 && !done; c++) begin
                drive($urandom % 4 != 0);
                if ($urandom % 8 == 0) trig_in = ~trig_in;
                force_trig = ($urandom % 40 == 0);
                if ($urandom % 300 == 0) begin
                    arm         = 1'b1;
                    pre_len     = AW'($urandom % 16);
                    post_len    = AW'($urandom % 16);
                    bus.s_valid = 1'b0;
                end
                if ($urandom % 500 == 0) rstn = 1'b0;
                tick();
                arm  = 1'b0;
                rstn = 1'b1;
            end
            force_trig = 0;
            drive(0);
            repeat (2) tick();
        end

        repeat (3) tick();
        chk("exp_wr_empty", exp_wr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
